// File: rtl/mips_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// mips_muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - md_op_e    : Op field encodings (bit1 = divide, bit0 = signed)
//     - md_state_e : sequencer states
//     - clog2()    : width of a down-counter that must hold WIDTH-1
// -----------------------------------------------------------------------------
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

  // Ceiling log2; for value >= 2 the result is enough bits to hold value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        result++;
        v = v >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_muldiv.sv
// -----------------------------------------------------------------------------
// mips_muldiv
//   Fixed-latency radix-2 multiply/divide unit with HI/LO result registers.
//   An operation accepted at edge t completes at edge t+WIDTH+1: WIDTH CALC
//   steps followed by one FIXUP cycle that applies signs and writes HI/LO.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   Start, Op, A, B   launch request and operands (sampled in IDLE only)
//   WrHi, WrLo, WrData MTHI/MTLO writes (honoured in IDLE only)
//   Busy              operation in flight (CALC or FIXUP)
//   Done              one-cycle pulse, HI/LO valid from that cycle
//   DivZero           last completed operation was a divide by zero
//   HI, LO            product high/low half, or remainder/quotient
// -----------------------------------------------------------------------------
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_OPS = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    count_q;
  logic             is_div_q;   // latched Op[1]
  logic             neg_q;      // result/quotient must be negated
  logic             sa_q;       // dividend sign, drives remainder sign
  logic             bzero_q;    // divisor was zero
  logic [WIDTH-1:0] a_raw_q;    // unmodified A, returned in HI on divide by zero
  logic [WIDTH-1:0] m_q;        // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi_q;   // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // multiplier being shifted out / quotient in
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             div_zero_q;

  // Operand conditioning at launch
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // One radix-2 step for each mode, then one mux on the latched Op[1]
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi, step_lo;

  // Sign correction applied in FIXUP
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=) to evaluate in order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = CALC;
      CALC:    if (count_q == '0) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sgn_op = SIGNED_OPS && Op[0];
    a_neg  = sgn_op & A[WIDTH-1];
    b_neg  = sgn_op & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);

    // Restoring divide: shift {hi, lo} left, trial-subtract the divisor.
    // The accepted remainder is below the divisor, so WIDTH bits suffice.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, m_q});
    div_rem   = div_shift[WIDTH-1:0] - m_q;

    if (is_div_q) begin
      step_hi = div_ok ? div_rem : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;

    if (!is_div_q) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (bzero_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      // Quotient negated when signs differ; remainder follows the dividend.
      // MIN / -1 falls out naturally: |MIN| negated wraps back to MIN.
      fix_hi = sa_q  ? -acc_hi_q : acc_hi_q;
      fix_lo = neg_q ? -acc_lo_q : acc_lo_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the accumulators and operand latches are reset along with HI/LO so a
  // reset mid-operation leaves no stale partial result behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      sa_q       <= 1'b0;
      bzero_q    <= 1'b0;
      a_raw_q    <= '0;
      m_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIXUP);
      case (state_q)
        IDLE: begin
          if (Start) begin
            is_div_q   <= Op[1];
            neg_q      <= a_neg ^ b_neg;
            sa_q       <= a_neg;
            bzero_q    <= (B == '0);
            a_raw_q    <= A;
            m_q        <= Op[1] ? b_mag : a_mag;
            acc_lo_q   <= Op[1] ? a_mag : b_mag;
            acc_hi_q   <= '0;
            count_q    <= CW'(WIDTH - 1);
            div_zero_q <= 1'b0;
          end
          // MTHI/MTLO only reach HI/LO while idle; FIXUP owns them otherwise.
          if (WrHi) hi_q <= WrData;
          if (WrLo) lo_q <= WrData;
        end
        CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        FIXUP: begin
          hi_q       <= fix_hi;
          lo_q       <= fix_lo;
          div_zero_q <= is_div_q & bzero_q;
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign DivZero = div_zero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv
//   Self-checking bench for mips_muldiv. Two instances: the default 32-bit
//   signed-capable unit and an 8-bit unsigned-only unit. Expected HI/LO come
//   from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_mips_muldiv;

  logic CLK;
  logic RST_N;

  // 32-bit signed-capable instance
  logic        start32, wrhi32, wrlo32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wrdata32;
  logic        busy32, done32, divzero32;
  logic [31:0] hi32, lo32;

  // 8-bit unsigned-only instance
  logic        start8, wrhi8, wrlo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wrdata8;
  logic        busy8, done8, divzero8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  mips_muldiv #(.WIDTH(32), .SIGNED_OPS(1'b1)) u_dut32 (
    .CLK(CLK), .RST_N(RST_N), .Start(start32), .Op(op32), .A(a32), .B(b32),
    .WrHi(wrhi32), .WrLo(wrlo32), .WrData(wrdata32), .Busy(busy32),
    .Done(done32), .DivZero(divzero32), .HI(hi32), .LO(lo32)
  );

  mips_muldiv #(.WIDTH(8), .SIGNED_OPS(1'b0)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .WrHi(wrhi8), .WrLo(wrlo8), .WrData(wrdata8), .Busy(busy8),
    .Done(done8), .DivZero(divzero8), .HI(hi8), .LO(lo8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL timeout global time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain arithmetic.
  function automatic void model32(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    longint sa, sb, q, r;
    dz = 1'b0;
    if (!op[1]) begin
      if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
      else       p = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  function automatic void model8(input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] hi,
                                 output logic [7:0] lo, output logic dz);
    logic [15:0] p;
    dz = 1'b0;
    if (!op[1]) begin
      p  = {8'b0, a} * {8'b0, b};
      hi = p[15:8];
      lo = p[7:0];
    end else if (b == 8'd0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endfunction

  // Entered and left 1 time unit after a rising edge. With disturb set, a
  // Start pulse and an MTLO write are presented mid-operation; both must be
  // ignored.
  task automatic do_op32(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
    logic [31:0] eh, el;
    logic        ed;
    int          done_k;
    bit          busy_ok;
    model32(op, a, b, eh, el, ed);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge CLK); #1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    done_k  = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 32 + 10; k++) begin
      @(posedge CLK); #1;
      if (done32) begin
        done_k = k;
        break;
      end
      if (!busy32) busy_ok = 1'b0;
      if (disturb && k == 5) begin
        start32 = 1'b1; op32 = 2'b00; wrlo32 = 1'b1; wrdata32 = 32'h55;
      end else begin
        start32 = 1'b0; wrlo32 = 1'b0;
      end
    end
    start32 = 1'b0; wrlo32 = 1'b0;
    check({tag, "_latency"}, 64'(done_k), 64'd33);
    check({tag, "_busy"},    64'(busy_ok), 64'd1);
    check({tag, "_hi"},      64'(hi32), 64'(eh));
    check({tag, "_lo"},      64'(lo32), 64'(el));
    check({tag, "_divzero"}, 64'(divzero32), 64'(ed));
  endtask

  task automatic do_op8(input string tag, input logic [1:0] op,
                        input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eh, el;
    logic       ed;
    int         done_k;
    model8(op, a, b, eh, el, ed);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge CLK); #1;
    start8 = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 8 + 10; k++) begin
      @(posedge CLK); #1;
      if (done8) begin
        done_k = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(done_k), 64'd9);
    check({tag, "_hi"},      64'(hi8), 64'(eh));
    check({tag, "_lo"},      64'(lo8), 64'(el));
    check({tag, "_divzero"}, 64'(divzero8), 64'(ed));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] lo_before;

    RST_N = 1'b0;
    start32 = 1'b0; wrhi32 = 1'b0; wrlo32 = 1'b0; op32 = '0;
    a32 = '0; b32 = '0; wrdata32 = '0;
    start8 = 1'b0; wrhi8 = 1'b0; wrlo8 = 1'b0; op8 = '0;
    a8 = '0; b8 = '0; wrdata8 = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy32",    64'(busy32), 64'd0);
    check("rst_done32",    64'(done32), 64'd0);
    check("rst_divzero32", 64'(divzero32), 64'd0);
    check("rst_hi32",      64'(hi32), 64'd0);
    check("rst_lo32",      64'(lo32), 64'd0);
    check("rst_busy8",     64'(busy8), 64'd0);
    check("rst_hi8",       64'(hi8), 64'd0);
    check("rst_lo8",       64'(lo8), 64'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Directed cases; consecutive calls also exercise back-to-back issue from
    // the Done cycle.
    do_op32("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(hi32), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(lo32), 64'h0000_0001);
    do_op32("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_lo_const", 64'(lo32), 64'hFFFF_FFEB);
    do_op32("div_neg",    2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", 64'(lo32), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(hi32), 64'hFFFF_FFFF);
    do_op32("divu_zero",  2'b10, 32'd100, 32'd0, 1'b0);
    check("divu_zero_hi_const", 64'(hi32), 64'h0000_0064);
    do_op32("div_zero_s", 2'b11, 32'h8000_0005, 32'd0, 1'b0);
    do_op32("div_minm1",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_minm1_lo_const", 64'(lo32), 64'h8000_0000);
    do_op32("div_rem_s",  2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op32("disturb",    2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    // Result holds, and no queued operation follows the ignored Start.
    @(posedge CLK); #1;
    check("idle_after_disturb", 64'(busy32), 64'd0);

    // MTHI in IDLE: visible next cycle, LO untouched.
    lo_before = lo32;
    wrhi32 = 1'b1; wrdata32 = 32'h1234;
    @(posedge CLK); #1;
    wrhi32 = 1'b0;
    check("mthi_hi", 64'(hi32), 64'h1234);
    check("mthi_lo", 64'(lo32), 64'(lo_before));
    wrlo32 = 1'b1; wrdata32 = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    wrlo32 = 1'b0;
    check("mtlo_lo", 64'(lo32), 64'hCAFE_F00D);

    // Reset in the middle of a MULTU aborts it immediately.
    start32 = 1'b1; op32 = 2'b00; a32 = 32'hDEAD_BEEF; b32 = 32'h1357_9BDF;
    @(posedge CLK); #1;
    start32 = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_hi",   64'(hi32), 64'd0);
    check("midrst_lo",   64'(lo32), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("midrst_stays_idle", 64'(busy32), 64'd0);
    check("midrst_no_done",    64'(done32), 64'd0);
    do_op32("after_rst", 2'b00, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0);

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      do_op32($sformatf("rnd32_%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0));
    end

    // 8-bit unsigned-only instance: Op[0] has no effect.
    do_op8("w8_mult_as_u", 2'b01, 8'hFF, 8'h02);
    check("w8_mult_hi_const", 64'(hi8), 64'h01);
    check("w8_mult_lo_const", 64'(lo8), 64'hFE);
    do_op8("w8_div_as_u",  2'b11, 8'hF9, 8'h02);
    do_op8("w8_div_zero",  2'b10, 8'h2A, 8'h00);
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      do_op8($sformatf("rnd8_%0d", i), rop, 8'($urandom),
             ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the multicycle MIPS core.
- Backs the MULT, MFHI and MFLO F-codes and adds MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU. The core FSM issues an operation with Start, stalls while Busy, and reads HI/LO combinationally for MFHI/MFLO.
- Generalises the current single-cycle ALU style to a WIDTH-bit, multi-mode, fixed-latency sequential unit.

Parameters:
- WIDTH, 32, operand/result width; legal values 4..64.
- SIGNED_OPS, 1, 1 enables signed MULT/DIV; 0 forces unsigned treatment of every Op.

Ports:
- CLK  in  1  clock, all state updates on posedge
- RST_N  in  1  asynchronous active-low reset
- Start  in  1  launch request, sampled only in IDLE
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; bit0 = signed
- A  in  WIDTH  multiplicand / dividend, sampled with Start
- B  in  WIDTH  multiplier / divisor, sampled with Start
- WrHi  in  1  MTHI write strobe
- WrLo  in  1  MTLO write strobe
- WrData  in  WIDTH  data for MTHI/MTLO
- Busy  out  1  high while an operation is in flight
- Done  out  1  one-cycle pulse; HI/LO valid from that cycle
- DivZero  out  1  sticky flag for the last completed operation: divide by zero
- HI  out  WIDTH  product high half / remainder
- LO  out  WIDTH  product low half / quotient

Behaviour:
- Reset (RST_N low, asynchronous):
  - State=IDLE.
  - Busy=0, Done=0, DivZero=0, HI=0, LO=0; internal accumulators cleared.
  - Reset mid-operation aborts with no HI/LO update.
- FSM states:
  - IDLE: Start=1 at an edge latches A, B and Op, captures operand signs, loads magnitudes (signed mode) or raw values, sets count=WIDTH-1 and goes to CALC. Otherwise stay.
  - CALC: one radix-2 step per cycle. When count=0 go to FIXUP, else decrement.
  - FIXUP: apply sign corrections, write HI/LO, assert Done, go to IDLE.
- Latency and handshake:
  - Start accepted at edge t. Busy=1 from t+1 through FIXUP.
  - Done=1 and HI/LO updated at edge t+WIDTH+1; Busy=0 from t+WIDTH+2.
  - Back-to-back: Start is accepted at the edge leaving the Done cycle only if the FSM is in IDLE, i.e. one cycle after Done.
  - Start while Busy: ignored, no queueing.
- Multiply:
  - Shift-add on unsigned magnitudes; 2*WIDTH-bit product {HI,LO}.
  - Signed: negate the 2*WIDTH result when sign(A) xor sign(B).
- Divide:
  - Restoring divide on magnitudes; LO=quotient, HI=remainder.
  - Signed: quotient negated when signs differ; remainder takes the sign of A.
  - MIN/-1 yields LO=MIN, HI=0, with no trap.
- Divide by zero (B=0, DIV/DIVU):
  - Same fixed latency.
  - LO = all ones, HI = A unmodified, DivZero=1.
  - DivZero is cleared on the next accepted Start.
- MTHI/MTLO:
  - WrHi/WrLo write HI/LO at the edge and take effect next cycle.
  - Honoured in IDLE only; ignored while Busy.
  - Completion (FIXUP) has priority over a same-cycle write.
- SIGNED_OPS=0: Op[0] is ignored and all operations are unsigned.
- HI/LO hold their value between completions and writes.

Decomposition:
- Package mips_muldiv_pkg holds:
  - the Op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV);
  - the FSM state encoding (IDLE, CALC, FIXUP);
  - the counter width function clog2(WIDTH).
- Single module; no sub-module is needed. The step datapath is one mux on Op[1].

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at t+33, HI=0xFFFFFFFE, LO=0x00000001, DivZero=0.
- MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=0x00000064, DivZero=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start pulse while Busy, plus WrLo=1 WrData=0x55 mid-op -> both ignored, first result unchanged. WrHi=1 WrData=0x1234 in IDLE -> HI=0x1234 next cycle.
- RST_N low for one cycle at t+10 of a MULTU -> Busy=0, HI=LO=0 immediately. Next Start completes normally with latency WIDTH+1.
- WIDTH=8, SIGNED_OPS=0 instance: Op=01, A=0xFF, B=0x02 -> unsigned result HI=0x01, LO=0xFE, Done at t+9.
